// File: rtl/mam_mem_sram.sv
// mam_mem_sram: beat-addressed SRAM with request, write-beat and read-beat handshakes.
// Optional out-of-range detection is enabled by defining MAM_MEM_RANGE_CHECK_EN.
module mam_mem_sram #(
   parameter int                    DATA_WIDTH = 512,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    MEM_WORDS  = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_rw,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic                    req_burst,
   input  logic [15:0]             req_size,
   input  logic                    write_valid,
   output logic                    write_ready,
   input  logic [DATA_WIDTH-1:0]   write_data,
   input  logic [DATA_WIDTH/8-1:0] write_strb,
   output logic                    read_valid,
   input  logic                    read_ready,
   output logic [DATA_WIDTH-1:0]   read_data,
   output logic                    range_err
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [ADDR_WIDTH-1:0] BYTES_A = ADDR_WIDTH'(BYTES);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ
   } state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
   logic [IDX_W-1:0]      r_idx;
   logic [15:0]           r_cnt;
   logic                  r_req_ready;
   logic                  r_wr_ready;
   logic                  r_rd_valid;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic [ADDR_WIDTH-1:0] w_off;
   logic [IDX_W-1:0]      w_idx;
   logic [IDX_W-1:0]      w_idx_nxt;
   logic [15:0]           w_cnt;

   // Offset from the base, converted to a beat index; the power-of-2
   // depth makes truncation the modulo, so stray addresses wrap.
   assign w_off     = req_addr - BASE_ADDR;
   assign w_idx     = IDX_W'(w_off / BYTES_A);
   assign w_idx_nxt = r_idx + IDX_W'(1);
   assign w_cnt     = (req_burst && (req_size != 16'd0)) ? req_size : 16'd1;

   assign req_ready   = r_req_ready;
   assign write_ready = r_wr_ready;
   assign read_valid  = r_rd_valid;
   assign read_data   = r_rdata;

   // Transfer FSM: accepts requests, counts beats, registers all handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_req_ready <= 1'b1;
         r_wr_ready  <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_rdata     <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_idx       <= w_idx;
                  r_cnt       <= w_cnt;
                  r_req_ready <= 1'b0;
                  if (req_rw) begin
                     r_state    <= WRITE;
                     r_wr_ready <= 1'b1;
                  end else begin
                     r_state    <= READ;
                     r_rd_valid <= 1'b1;
                     r_rdata    <= r_mem[w_idx];
                  end
               end
            end
            WRITE: begin
               if (write_valid) begin
                  r_idx <= w_idx_nxt;
                  r_cnt <= r_cnt - 16'd1;
                  if (r_cnt == 16'd1) begin
                     r_state     <= IDLE;
                     r_wr_ready  <= 1'b0;
                     r_req_ready <= 1'b1;
                  end
               end
            end
            READ: begin
               if (read_ready) begin
                  if (r_cnt == 16'd1) begin
                     r_state     <= IDLE;
                     r_rd_valid  <= 1'b0;
                     r_req_ready <= 1'b1;
                  end else begin
                     r_rdata <= r_mem[w_idx_nxt];
                     r_idx   <= w_idx_nxt;
                     r_cnt   <= r_cnt - 16'd1;
                  end
               end
            end
            default: begin
               r_state     <= IDLE;
               r_req_ready <= 1'b1;
               r_wr_ready  <= 1'b0;
               r_rd_valid  <= 1'b0;
            end
         endcase
      end
   end

   // Byte-masked storage update; memory is never cleared by reset.
   always_ff @(posedge clk) begin
      if (r_wr_ready && write_valid) begin
         for (int b = 0; b < BYTES; b++) begin
            if (write_strb[b]) begin
               r_mem[r_idx][b*8 +: 8] <= write_data[b*8 +: 8];
            end
         end
      end
   end

`ifdef MAM_MEM_RANGE_CHECK_EN
   localparam logic [ADDR_WIDTH:0] LIMIT =
      {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(MEM_WORDS * BYTES);

   logic w_oor;
   logic r_range_err;

   assign w_oor = (req_addr < BASE_ADDR) ||
                  ({1'b0, req_addr} >= LIMIT);
   assign range_err = r_range_err;

   // One-cycle flag for an accepted request outside the mapped window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_range_err <= 1'b0;
      end else begin
         r_range_err <= (r_state == IDLE) && req_valid && w_oor;
      end
   end
`else
   assign range_err = 1'b0;
`endif

endmodule
